// File: rtl/obi_sram_bridge_if.sv
// obi_sram_bridge_if: OBI request/response bundle (REQ WE BE ADDR WDATA from master; GNT RVALID RDATA from slave)
interface obi_sram_bridge_if;
  logic        REQ;
  logic        WE;
  logic [3:0]  BE;
  logic [23:0] ADDR;
  logic [31:0] WDATA;
  logic        GNT;
  logic        RVALID;
  logic [31:0] RDATA;
  modport master (output REQ, WE, BE, ADDR, WDATA, input GNT, RVALID, RDATA);
  modport slave (input REQ, WE, BE, ADDR, WDATA, output GNT, RVALID, RDATA);
endinterface

// File: rtl/obi_sram_bridge.sv
// obi_sram_bridge: OBI slave onto a 1024x32 SRAM (clk, rst, obi slave port, AD/BEN/DI/EN/R_WB/DO SRAM pins, clear_req, busy, err_cnt) with post-reset/requested clear sweep; define OBI_SRAM_BRIDGE_RDATA_REG_EN for a registered 2-cycle response
module obi_sram_bridge #(
  parameter logic [11:0] BASE = 12'h000,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  obi_sram_bridge_if.slave     obi,
  output logic [9:0]           AD,
  output logic [31:0]          BEN,
  output logic [31:0]          DI,
  output logic                 EN,
  output logic                 R_WB,
  input  logic [31:0]          DO,
  input  logic                 clear_req,
  output logic                 busy,
  output logic [7:0]           err_cnt
);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;
  logic [0:0] state;
  logic [9:0] cnt;
  logic       hold;
  logic       rv;
  logic       rv_rd;
  logic       pend;
  logic       acc;
  logic       hit;
  logic       sel;
  logic       clr;
  logic       sweep;
  logic       unused;
  assign unused = ^obi.ADDR[1:0];
  assign sweep  = ~rst & (state == CLEAR);
  assign busy   = sweep;
  assign clr    = clear_req | hold;
  assign obi.GNT = ~rst & (state == RUN) & ~clr;
  assign acc    = obi.REQ & obi.GNT;
  assign hit    = obi.ADDR[23:12] == BASE;
  assign sel    = acc & hit;
  assign EN     = sweep | sel;
  assign R_WB   = sel & ~obi.WE;
  assign AD     = sweep ? cnt : sel ? obi.ADDR[11:2] : '0;
  assign BEN    = sweep ? '1 : sel ? {{8{obi.BE[3]}}, {8{obi.BE[2]}}, {8{obi.BE[1]}}, {8{obi.BE[0]}}} : '0;
  assign DI     = sel ? obi.WDATA : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rv    <= 1'b0;
      rv_rd <= 1'b0;
    end else begin
      rv    <= acc;
      rv_rd <= sel & ~obi.WE;
    end
  end
`ifdef OBI_SRAM_BRIDGE_RDATA_REG_EN
  logic        rv2;
  logic [31:0] rd2;
  always_ff @(posedge clk) begin
    if (rst) begin
      rv2 <= 1'b0;
      rd2 <= '0;
    end else begin
      rv2 <= rv;
      rd2 <= (rv & rv_rd) ? DO : '0;
    end
  end
  assign pend       = rv | rv2;
  assign obi.RVALID = ~rst & rv2;
  assign obi.RDATA  = rst ? '0 : rd2;
`else
  assign pend       = rv;
  assign obi.RVALID = ~rst & rv;
  assign obi.RDATA  = (~rst & rv & rv_rd) ? DO : '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt     <= '0;
      hold    <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (state == CLEAR) begin
        cnt <= cnt + 10'd1;
        if (cnt == 10'd1023) state <= RUN;
      end else if (clr) begin
        hold <= pend;
        if (!pend) begin
          state <= CLEAR;
          cnt   <= '0;
        end
      end
      if (acc && !hit && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_obi_sram_bridge.sv
// tb_obi_sram_bridge: directed self-checking bench for obi_sram_bridge with a behavioural SRAM
module tb_obi_sram_bridge;
`ifdef OBI_SRAM_BRIDGE_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  obi_sram_bridge_if a();
  obi_sram_bridge_if b();
  logic [9:0]  ad0, ad1;
  logic [31:0] ben0, di0, do0, ben1, di1;
  logic [31:0] do1 = 32'hDEADBEEF;
  logic        en0, rwb0, en1, rwb1, busy0, busy1;
  logic        clr0 = 1'b0;
  logic        clr1 = 1'b0;
  logic [7:0]  err0, err1;
  obi_sram_bridge dut0 (
    .clk(clk), .rst(rst), .obi(a), .AD(ad0), .BEN(ben0), .DI(di0), .EN(en0), .R_WB(rwb0),
    .DO(do0), .clear_req(clr0), .busy(busy0), .err_cnt(err0)
  );
  obi_sram_bridge #(.BASE(12'h001), .CLEAR_ON_RESET(1'b0)) dut1 (
    .clk(clk), .rst(rst), .obi(b), .AD(ad1), .BEN(ben1), .DI(di1), .EN(en1), .R_WB(rwb1),
    .DO(do1), .clear_req(clr1), .busy(busy1), .err_cnt(err1)
  );
  logic [31:0] mem [1024];
  always @(posedge clk)
    if (en0) begin
      if (rwb0) do0 <= mem[ad0];
      else mem[ad0] <= (mem[ad0] & ~ben0) | (di0 & ben0);
    end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [31:0] q_d [$];
  int          q_c [$];
  int          rdz_bad = 0;
  always @(negedge clk)
    if (a.RVALID === 1'b1) begin
      q_d.push_back(a.RDATA);
      q_c.push_back(cyc);
    end else if (a.RDATA !== 32'h0) rdz_bad++;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_rsp(input string tag, input int k, input logic [31:0] ed, input int ec);
    logic [31:0] d;
    int c;
    d = k < q_d.size() ? q_d[k] : 32'hxxxxxxxx;
    c = k < q_c.size() ? q_c[k] : -1;
    chk({tag, "_data"}, d, ed);
    chk({tag, "_cyc"}, c, ec);
  endtask
  task automatic drive(input logic we, input logic [3:0] be, input logic [23:0] addr, input logic [31:0] wd);
    a.REQ = 1'b1;
    a.WE = we;
    a.BE = be;
    a.ADDR = addr;
    a.WDATA = wd;
  endtask
  task automatic idle();
    a.REQ = 1'b0;
    a.WE = 1'b0;
    a.BE = '0;
    a.ADDR = '0;
    a.WDATA = '0;
  endtask
  task automatic count_sweep(input string tag);
    int n;
    n = 0;
    while (busy0 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy0 === 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk(tag, n, 1024);
  endtask
  initial begin
    int bad, c0, c1, c2, c3;
    logic [31:0] w;
    idle();
    b.REQ = 1'b0;
    b.WE = 1'b0;
    b.BE = 4'hF;
    b.ADDR = 24'h002000;
    b.WDATA = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", a.GNT, 0);
    chk("rst_rvalid", a.RVALID, 0);
    chk("rst_rdata", a.RDATA, 0);
    chk("rst_en", en0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_gnt_b", b.GNT, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("noclear_gnt_b", b.GNT, 1);
    chk("noclear_busy_b", busy1, 0);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (busy0 !== 1'b1 || ad0 !== 10'(i) || di0 !== 32'h0 || en0 !== 1'b1 || rwb0 !== 1'b0 ||
          ben0 !== 32'hFFFFFFFF || a.GNT !== 1'b0) bad++;
      @(negedge clk);
      #1;
    end
    chk("sweep_bad_cycles", bad, 0);
    chk("post_sweep_busy", busy0, 0);
    chk("post_sweep_gnt", a.GNT, 1);
    chk("idle_en", en0, 0);
    chk("idle_ad", ad0, 0);
    chk("idle_ben_di", ben0 | di0, 0);
    chk("idle_rwb", rwb0, 0);
    q_d.delete();
    q_c.delete();
    drive(1'b1, 4'b0101, 24'h000010, 32'hA5A5A5A5);
    #1;
    c0 = cyc;
    chk("wr_en", en0, 1);
    chk("wr_rwb", rwb0, 0);
    chk("wr_ad", ad0, 4);
    chk("wr_ben", ben0, 32'h00FF00FF);
    chk("wr_di", di0, 32'hA5A5A5A5);
    @(negedge clk);
    drive(1'b0, 4'b1111, 24'h000010, 32'h0);
    #1;
    c1 = cyc;
    chk("rd_en", en0, 1);
    chk("rd_rwb", rwb0, 1);
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);
    #1;
    chk("wr_rd_rsp_count", q_d.size(), 2);
    chk_rsp("wr_rsp", 0, 32'h0, c0 + LAT);
    chk_rsp("rd_rsp", 1, 32'h00A500A5, c1 + LAT);
    for (int k = 0; k < 4; k++) begin
      w = 32'h11111111 * (k + 1);
      drive(1'b1, 4'hF, 24'h000020 + 24'(4 * k), w);
      @(negedge clk);
    end
    idle();
    repeat (4) @(negedge clk);
    q_d.delete();
    q_c.delete();
    c2 = cyc;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 4'hF, 24'h000020 + 24'(4 * k), 32'h0);
      @(negedge clk);
    end
    idle();
    repeat (5) @(negedge clk);
    #1;
    chk("b2b_rsp_count", q_d.size(), 4);
    for (int k = 0; k < 4; k++) begin
      w = 32'h11111111 * (k + 1);
      chk_rsp($sformatf("b2b_rsp%0d", k), k, w, c2 + LAT + k);
    end
    b.REQ = 1'b1;
    #1;
    chk("miss_gnt", b.GNT, 1);
    chk("miss_en", en1, 0);
    @(negedge clk);
    b.REQ = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    #1;
    chk("miss_rvalid", b.RVALID, 1);
    chk("miss_rdata", b.RDATA, 0);
    chk("miss_err", err1, 1);
    b.REQ = 1'b1;
    repeat (300) @(negedge clk);
    b.REQ = 1'b0;
    #1;
    chk("miss_err_sat", err1, 255);
    q_d.delete();
    q_c.delete();
    drive(1'b0, 4'hF, 24'h000010, 32'h0);
    c3 = cyc;
    @(negedge clk);
    idle();
    clr0 = 1'b1;
    #1;
    chk("clr_gnt_drop", a.GNT, 0);
    @(negedge clk);
    clr0 = 1'b0;
    count_sweep("clr_sweep_len");
    chk("clr_gnt_after", a.GNT, 1);
    chk("clr_rsp_count", q_d.size(), 1);
    chk_rsp("clr_rsp", 0, 32'h00A500A5, c3 + LAT);
    q_d.delete();
    q_c.delete();
    drive(1'b0, 4'hF, 24'h000010, 32'h0);
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pend_rvalid", a.RVALID, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_err_b", err1, 0);
    chk("resweep_busy", busy0, 1);
    chk("resweep_ad0", ad0, 0);
    repeat (500) @(negedge clk);
    #1;
    chk("sweep500_ad", ad0, 500);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("restart_ad", ad0, 0);
    chk("restart_busy", busy0, 1);
    count_sweep("restart_sweep_len");
    repeat (3) @(negedge clk);
    #1;
    chk("no_spurious_rvalid", q_d.size(), 0);
    chk("rdata_zero_when_idle", rdz_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/obi_sram_bridge.md
OBI_SRAM_BRIDGE -- requirements
Module: obi_sram_bridge

Interface
REQ-001 Parameter BASE, default 12'h000: SHALL be the value matched against ADDR[23:12] for an in-range access.
REQ-002 Parameter CLEAR_ON_RESET, default 1: when 1, SHALL start a full SRAM clear sweep after reset.
REQ-003 Port clk, input, 1: SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: SHALL be the reset, synchronous and active-high.
REQ-005 Ports REQ, WE, BE[3:0], ADDR[23:0], WDATA[31:0], inputs: SHALL form the OBI request from the CPU peripheral interface.
REQ-006 Ports GNT, RVALID, RDATA[31:0], outputs: SHALL form the OBI grant and response.
REQ-007 Ports AD[9:0], BEN[31:0], DI[31:0], EN, R_WB, outputs, and DO[31:0], input: SHALL connect to the 1024x32 SRAM wrapper.
REQ-008 Port clear_req, input, 1: SHALL request a clear sweep.
REQ-009 Ports busy (1) and err_cnt (8), outputs: busy SHALL flag a sweep in progress; err_cnt SHALL count out-of-range accesses.

Function
REQ-010 FSM states SHALL be CLEAR and RUN; CLEAR→RUN when the sweep address reaches 1023; RUN→CLEAR on clear_req=1 with no response pending.
REQ-011 CLEAR: GNT=0, busy=1, EN=1, R_WB=0, BEN=all ones, DI=0, AD=sweep counter incrementing 0..1023 by one each cycle (1024 cycles).
REQ-012 RUN: GNT=1 combinationally; a handshake SHALL be REQ&GNT in the same cycle.
REQ-013 Hit SHALL be ADDR[23:12]==BASE; AD=ADDR[11:2]; ADDR[1:0] SHALL be ignored.
REQ-014 Accepted hit: EN=1 in the accept cycle; R_WB=~WE; BEN[8k+7:8k]=replicated BE[k]; DI=WDATA.
REQ-015 Accepted miss: EN=0, write dropped, err_cnt incremented, saturating at 255.
REQ-016 Each accepted request SHALL produce exactly one single-cycle RVALID pulse, in order; there is no response backpressure.
REQ-017 Response latency SHALL be 1 cycle after accept (see REQ-024); back-to-back accepts SHALL give 1 response per cycle.
REQ-018 RDATA SHALL be DO for a hit read and 32'h0 for writes and misses; RDATA SHALL be 0 whenever RVALID=0.
REQ-019 clear_req while a response is pending SHALL be held and acted on the cycle after the last RVALID; GNT SHALL drop from the cycle clear_req is sampled high.
REQ-020 Idle SRAM outputs (EN=0) SHALL drive AD, BEN, DI, R_WB to 0.

Reset
REQ-021 rst=1 SHALL clear the FSM, sweep counter, response pipeline and err_cnt. If CLEAR_ON_RESET=1, the FSM SHALL go to CLEAR at address 0; otherwise it SHALL go to RUN.
REQ-022 During rst, outputs SHALL be GNT=0, RVALID=0, RDATA=0, EN=0, busy=0.
REQ-023 rst asserted mid-sweep or with a response pending SHALL discard that state; no RVALID SHALL follow reset.

Configuration
REQ-024 Macro OBI_SRAM_BRIDGE_RDATA_REG_EN: when defined, RDATA/RVALID SHALL pass through an extra register stage, making response latency 2 cycles with throughput unchanged; when undefined, latency SHALL be 1 cycle.

Verification
REQ-025 CLEAR_ON_RESET=1, release rst: busy=1 for exactly 1024 cycles, AD steps 0..1023 with DI=0, then GNT=1.
REQ-026 Write 0xA5A5A5A5 at ADDR 0x000010 with BE=4'b0101, then read the same address: RDATA=0x00A500A5 (after clear), RVALID 1 cycle after accept (2 cycles with macro).
REQ-027 Four back-to-back reads on consecutive cycles: four consecutive RVALID pulses, data in request order.
REQ-028 BASE=12'h001, access ADDR=0x002000: no EN, RDATA=0 with RVALID, err_cnt+1; 300 misses: err_cnt=255.
REQ-029 clear_req on the cycle after a read accept: the read's RVALID still occurs; GNT=0 then 1024 clear cycles.
REQ-030 rst pulse on sweep cycle 500: sweep restarts at AD=0; no spurious RVALID.
